// File: rtl/cmp_pkg.sv
// cmp_pkg: condition codes, comparator result encodings and FSM states for the compare sequencer
package cmp_pkg;
  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_GE = 3'd3;
  localparam logic [2:0] COND_GT = 3'd4;
  localparam logic [2:0] COND_LE = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER = 3'd7;
  localparam logic [1:0] RES_LT = 2'b11;
  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/cmp_cond_seq_if.sv
// cmp_cond_seq_if: request/result handshake bundle between a requester and the compare sequencer
interface cmp_cond_seq_if #(parameter int DATA_W = 16);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0] in_cond;
  logic out_valid;
  logic out_ready;
  logic out_true;
  logic [2:0] out_flags;
  logic out_err;
  modport master (output in_valid, in_a, in_b, in_cond, out_ready, input in_ready, out_valid, out_true, out_flags, out_err);
  modport slave (input in_valid, in_a, in_b, in_cond, out_ready, output in_ready, out_valid, out_true, out_flags, out_err);
endinterface

// File: rtl/cmp_cond_decode.sv
// cmp_cond_decode: maps a comparator result and condition code to flags, outcome and illegal-result error
module cmp_cond_decode
  import cmp_pkg::*;
(
  input  logic [1:0] i_res,
  input  logic [2:0] i_cond,
  output logic [2:0] o_flags,
  output logic o_true,
  output logic o_err
);
  logic w_lt, w_eq, w_gt;
  logic [7:0] w_tab;
  assign w_lt = i_res == RES_LT;
  assign w_eq = i_res == RES_EQ;
  assign w_gt = i_res == RES_GT;
  assign o_err = i_res == 2'b10;
  assign o_flags = {w_gt, w_eq, w_lt};
  // outcome per condition code, indexed by the code itself (NEVER at bit 7, EQ at bit 0)
  assign w_tab = {1'b0, 1'b1, w_lt | w_eq, w_gt, w_gt | w_eq, w_lt, ~w_eq, w_eq};
  // an illegal result never yields a true outcome, whatever the condition
  assign o_true = ~o_err & w_tab[i_cond];
endmodule

// File: rtl/comparator_16bit.sv
// Comparator_16bit: combinational signed comparator returning -1/0/+1 as a 2-bit code
module Comparator_16bit
  import cmp_pkg::*;
(
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic [1:0] res
);
  assign res = a < b ? RES_LT : a == b ? RES_EQ : RES_GT;
endmodule

// File: rtl/cmp_cond_seq.sv
// cmp_cond_seq: sequences compare requests through the ALU comparator and returns condition outcomes; CMP_CG_EN adds cg_en and keeps operands held
module cmp_cond_seq
  import cmp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  cmp_cond_seq_if.slave bus,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic [1:0] cmp_res,
`ifdef CMP_CG_EN
  output logic cg_en,
`endif
  output logic [CNT_W-1:0] true_cnt
);
  state_t r_state, w_next;
  logic [2:0] r_cond;
  logic [2:0] w_flags;
  logic w_true, w_err;
  cmp_cond_decode u_dec (.i_res(cmp_res), .i_cond(r_cond), .o_flags(w_flags), .o_true(w_true), .o_err(w_err));
  assign bus.in_ready = r_state == IDLE;
`ifdef CMP_CG_EN
  assign cg_en = r_state == DRIVE;
`endif
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // IDLE waits for a request, DRIVE lasts one cycle, DONE waits for the consumer
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (bus.in_valid ? DRIVE : IDLE) :
             r_state == DRIVE ? DONE : (bus.out_ready ? IDLE : DONE);
  end
  // operand, result and counter registers
  always_ff @(posedge clk)
    if (rst) begin
      cmp_a <= '0;
      cmp_b <= '0;
      r_cond <= '0;
      bus.out_valid <= 1'b0;
      bus.out_true <= 1'b0;
      bus.out_flags <= '0;
      bus.out_err <= 1'b0;
      true_cnt <= '0;
    end else begin
      if (r_state == IDLE && bus.in_valid) begin
        cmp_a <= bus.in_a;
        cmp_b <= bus.in_b;
        r_cond <= bus.in_cond;
      end
      if (r_state == DRIVE) begin
`ifndef CMP_CG_EN
        cmp_a <= '0;
        cmp_b <= '0;
`endif
        bus.out_valid <= 1'b1;
        bus.out_true <= w_true;
        bus.out_flags <= w_flags;
        bus.out_err <= w_err;
      end
      if (r_state == DONE && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        true_cnt <= true_cnt + CNT_W'(bus.out_true & ~&true_cnt);
      end
    end
endmodule
